// File: rtl/alu2.sv
// Accumulator ALU: one signed accumulator updated from ACC and a muxed operand B.
// Supports add, load and a fixed-point multiply by a Q-format immediate.
module alu2 #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned FRAC_BITS = 3
) (
  input  logic                    Clock,
  input  logic                    nReset,
  input  logic [2:0]              Func,
  input  logic                    WE,
  input  logic                    SelImm,
  input  logic                    SelSW,
  input  logic signed [WIDTH-1:0] Imm,
  input  logic signed [WIDTH-1:0] SW,
  input  logic signed [WIDTH-1:0] RegData,
  output logic signed [WIDTH-1:0] ACC
);

  localparam int unsigned PROD_W = 2 * WIDTH;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_RTA  = 3'b001;
  localparam logic [2:0] OP_HEI  = 3'b010;
  localparam logic [2:0] OP_LSW  = 3'b011;
  localparam logic [2:0] OP_ADDI = 3'b100;
  localparam logic [2:0] OP_MULI = 3'b101;
  localparam logic [2:0] OP_ATR  = 3'b110;

  logic signed [WIDTH-1:0]  b_c;
  logic signed [WIDTH-1:0]  sum_c;
  logic signed [WIDTH-1:0]  mul_c;
  logic signed [WIDTH-1:0]  result_c;
  logic                     write_c;
  logic signed [PROD_W-1:0] acc_x_c;
  logic signed [PROD_W-1:0] b_x_c;
  logic signed [PROD_W-1:0] prod_c;

  // Operand B mux; the immediate select wins over the switch select.
  always_comb begin
    b_c = RegData;
    if (SelImm) begin
      b_c = Imm;
    end else if (SelSW) begin
      b_c = SW;
    end
  end

  assign sum_c = ACC + b_c;

  // Full-width signed product, then floor-shift out the fraction and wrap.
  assign acc_x_c = {{WIDTH{ACC[WIDTH-1]}}, ACC};
  assign b_x_c   = {{WIDTH{b_c[WIDTH-1]}}, b_c};
  assign prod_c  = acc_x_c * b_x_c;
  assign mul_c   = WIDTH'(prod_c >>> FRAC_BITS);

  always_comb begin
    result_c = ACC;
    write_c  = 1'b0;
    case (Func)
      OP_ADD, OP_ADDI: begin
        result_c = sum_c;
        write_c  = 1'b1;
      end
      OP_RTA, OP_LSW: begin
        result_c = b_c;
        write_c  = 1'b1;
      end
      OP_MULI: begin
        result_c = mul_c;
        write_c  = 1'b1;
      end
      OP_HEI, OP_ATR: begin
        result_c = ACC;
        write_c  = 1'b0;
      end
      default: begin
        result_c = ACC;
        write_c  = 1'b0;
      end
    endcase
  end

  // The accumulator is the only state in the block.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      ACC <= '0;
    end else if (WE && write_c) begin
      ACC <= result_c;
    end
  end

endmodule

// File: tb/tb_alu2.sv
// Self-checking bench for alu2: directed scenarios with fixed expectations plus
// a random back-to-back run checked against an arithmetic reference model.
module tb_alu2;

  logic              Clock;
  logic              nReset;
  logic [2:0]        Func;
  logic              WE;
  logic              SelImm;
  logic              SelSW;
  logic signed [7:0] Imm;
  logic signed [7:0] SW;
  logic signed [7:0] RegData;
  logic signed [7:0] ACC;

  int checks   = 0;
  int failures = 0;

  logic signed [7:0] sb[$];
  logic signed [7:0] acc_model;
  logic signed [7:0] exp_v;

  alu2 #(.WIDTH(8), .FRAC_BITS(3)) dut (
    .Clock(Clock), .nReset(nReset), .Func(Func), .WE(WE),
    .SelImm(SelImm), .SelSW(SelSW), .Imm(Imm), .SW(SW),
    .RegData(RegData), .ACC(ACC)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Reference: integer arithmetic with explicit floor division by 8.
  function automatic logic signed [7:0] model(input logic signed [7:0] acc,
      input logic [2:0] f, input logic we, input logic si, input logic ss,
      input logic signed [7:0] imm, input logic signed [7:0] sw,
      input logic signed [7:0] rd);
    int b;
    int p;
    int r;
    b = si ? int'(imm) : (ss ? int'(sw) : int'(rd));
    r = int'(acc);
    if (we) begin
      case (f)
        3'd0, 3'd4: r = int'(acc) + b;
        3'd1, 3'd3: r = b;
        3'd5: begin
          p = int'(acc) * b;
          r = (p - (((p % 8) + 8) % 8)) / 8;
        end
        default: r = int'(acc);
      endcase
    end
    return r[7:0];
  endfunction

  // Drive one operation between edges, queue its expected result, then
  // advance past the sampling edge.
  task automatic drive(input logic [2:0] f, input logic we, input logic si,
      input logic ss, input logic signed [7:0] imm, input logic signed [7:0] sw,
      input logic signed [7:0] rd, input logic signed [7:0] expv);
    @(negedge Clock);
    Func = f; WE = we; SelImm = si; SelSW = ss; Imm = imm; SW = sw; RegData = rd;
    sb.push_back(expv);
    acc_model = expv;
    @(posedge Clock);
    #1;
  endtask

  task automatic pop_exp(output logic signed [7:0] v);
    if (sb.size() == 0) begin
      v = 8'sh00;
      failures++;
      $display("FAIL scoreboard_empty: no expected value queued");
    end else begin
      v = sb.pop_front();
    end
  endtask

  task automatic test_reset;
    Func = 3'd0; WE = 1'b0; SelImm = 1'b0; SelSW = 1'b0;
    Imm = 8'sh00; SW = 8'sh00; RegData = 8'sh00;
    nReset = 1'b1;
    #2 nReset = 1'b0;
    #1;
    checks++;
    if (ACC !== 8'sh00) begin
      failures++; $display("FAIL power_on_reset: acc=%0d want=0", ACC);
    end
    @(negedge Clock); nReset = 1'b1;
    acc_model = 8'sh00;
    drive(3'd3, 1'b1, 1'b0, 1'b1, 8'sh00, 8'sh55, 8'sh00, 8'sh55);
    pop_exp(exp_v); checks++;
    if (ACC !== exp_v) begin
      failures++; $display("FAIL load_55: acc=%0d want=%0d", ACC, exp_v);
    end
    @(negedge Clock);
    #2 nReset = 1'b0;
    #1;
    checks++;
    if (ACC !== 8'sh00) begin
      failures++; $display("FAIL async_reset: acc=%0d want=0", ACC);
    end
    Func = 3'd3; WE = 1'b1; SelSW = 1'b1; SW = 8'sh33;
    for (int i = 0; i < 3; i++) begin
      @(posedge Clock); #1;
      checks++;
      if (ACC !== 8'sh00) begin
        failures++; $display("FAIL reset_hold edge=%0d: acc=%0d want=0", i, ACC);
      end
    end
    @(negedge Clock); nReset = 1'b1; WE = 1'b0;
    sb.delete();
    acc_model = 8'sh00;
  endtask

  task automatic test_load_scale;
    drive(3'd3, 1'b1, 1'b0, 1'b1, 8'sh00, 8'sd40, 8'sh00, 8'sd40);
    pop_exp(exp_v); checks++;
    if (ACC !== exp_v) begin
      failures++; $display("FAIL lsw_40: acc=%0d want=%0d", ACC, exp_v);
    end
    drive(3'd5, 1'b1, 1'b1, 1'b0, 8'sd6, 8'sh00, 8'sh00, 8'sd30);
    pop_exp(exp_v); checks++;
    if (ACC !== exp_v) begin
      failures++; $display("FAIL muli_0p75: acc=%0d want=%0d", ACC, exp_v);
    end
    drive(3'd5, 1'b1, 1'b1, 1'b0, 8'sd4, 8'sh00, 8'sh00, 8'sd15);
    pop_exp(exp_v); checks++;
    if (ACC !== exp_v) begin
      failures++; $display("FAIL muli_0p5: acc=%0d want=%0d", ACC, exp_v);
    end
  endtask

  task automatic test_neg_scale;
    drive(3'd1, 1'b1, 1'b0, 1'b0, 8'sh00, 8'sh00, 8'sd40, 8'sd40);
    pop_exp(exp_v); checks++;
    if (ACC !== exp_v) begin
      failures++; $display("FAIL rta_40: acc=%0d want=%0d", ACC, exp_v);
    end
    drive(3'd5, 1'b1, 1'b1, 1'b0, 8'shFC, 8'sh00, 8'sh00, 8'shEC);
    pop_exp(exp_v); checks++;
    if (ACC !== exp_v) begin
      failures++; $display("FAIL muli_neg_half: acc=%0d want=%0d", ACC, exp_v);
    end
    drive(3'd3, 1'b1, 1'b0, 1'b1, 8'sh00, -8'sd5, 8'sh00, -8'sd5);
    pop_exp(exp_v); checks++;
    if (ACC !== exp_v) begin
      failures++; $display("FAIL lsw_m5: acc=%0d want=%0d", ACC, exp_v);
    end
    drive(3'd5, 1'b1, 1'b1, 1'b0, 8'sd6, 8'sh00, 8'sh00, -8'sd4);
    pop_exp(exp_v); checks++;
    if (ACC !== exp_v) begin
      failures++; $display("FAIL muli_floor: acc=%0d want=%0d", ACC, exp_v);
    end
  endtask

  task automatic test_add;
    drive(3'd3, 1'b1, 1'b0, 1'b1, 8'sh00, 8'sd20, 8'sh00, 8'sd20);
    pop_exp(exp_v);
    drive(3'd0, 1'b1, 1'b0, 1'b0, 8'sh00, 8'sh00, 8'sd30, 8'sd50);
    pop_exp(exp_v); checks++;
    if (ACC !== exp_v) begin
      failures++; $display("FAIL add_reg: acc=%0d want=%0d", ACC, exp_v);
    end
    drive(3'd4, 1'b1, 1'b1, 1'b0, 8'shEC, 8'sh00, 8'sh00, 8'sd30);
    pop_exp(exp_v); checks++;
    if (ACC !== exp_v) begin
      failures++; $display("FAIL addi_neg: acc=%0d want=%0d", ACC, exp_v);
    end
  endtask

  task automatic test_hold_wrap;
    for (int i = 0; i < 3; i++) begin
      drive(3'd0, 1'b0, 1'b0, 1'b0, 8'sh00, 8'sh00, 8'sd5, 8'sd30);
      pop_exp(exp_v); checks++;
      if (ACC !== exp_v) begin
        failures++; $display("FAIL hold_we0 edge=%0d: acc=%0d want=%0d", i, ACC, exp_v);
      end
    end
    for (int i = 0; i < 3; i++) begin
      logic [2:0] f;
      f = (i == 0) ? 3'd6 : ((i == 1) ? 3'd2 : 3'd7);
      drive(f, 1'b1, 1'b1, 1'b0, 8'sd9, 8'sh00, 8'sh00, 8'sd30);
      pop_exp(exp_v); checks++;
      if (ACC !== exp_v) begin
        failures++; $display("FAIL hold_func=%0d: acc=%0d want=%0d", f, ACC, exp_v);
      end
    end
    drive(3'd3, 1'b1, 1'b0, 1'b1, 8'sh00, 8'sd127, 8'sh00, 8'sd127);
    pop_exp(exp_v);
    drive(3'd4, 1'b1, 1'b1, 1'b0, 8'sd20, 8'sh00, 8'sh00, 8'sh93);
    pop_exp(exp_v); checks++;
    if (ACC !== exp_v) begin
      failures++; $display("FAIL addi_wrap: acc=%0d want=%0d", ACC, exp_v);
    end
  endtask

  task automatic test_select_priority;
    drive(3'd3, 1'b1, 1'b1, 1'b1, 8'sd12, 8'sd99, 8'sd7, 8'sd12);
    pop_exp(exp_v); checks++;
    if (ACC !== exp_v) begin
      failures++; $display("FAIL sel_imm_over_sw: acc=%0d want=%0d", ACC, exp_v);
    end
    drive(3'd1, 1'b1, 1'b0, 1'b1, 8'sd12, 8'sd99, 8'sd7, 8'sd99);
    pop_exp(exp_v); checks++;
    if (ACC !== exp_v) begin
      failures++; $display("FAIL sel_sw: acc=%0d want=%0d", ACC, exp_v);
    end
    drive(3'd0, 1'b1, 1'b0, 1'b0, 8'sd12, 8'sd99, 8'sd7, 8'sd106);
    pop_exp(exp_v); checks++;
    if (ACC !== exp_v) begin
      failures++; $display("FAIL sel_reg: acc=%0d want=%0d", ACC, exp_v);
    end
  endtask

  task automatic test_back_to_back;
    logic [2:0]        f;
    logic              we, si, ss;
    logic signed [7:0] imm, sw, rd;
    for (int i = 0; i < 300; i++) begin
      f   = 3'($urandom_range(0, 7));
      we  = ($urandom_range(0, 3) != 0);
      si  = 1'($urandom);
      ss  = 1'($urandom);
      imm = 8'($urandom);
      sw  = 8'($urandom);
      rd  = 8'($urandom);
      drive(f, we, si, ss, imm, sw, rd, model(acc_model, f, we, si, ss, imm, sw, rd));
      pop_exp(exp_v); checks++;
      if (ACC !== exp_v) begin
        failures++;
        $display("FAIL b2b i=%0d func=%0d we=%0b si=%0b ss=%0b: acc=%0d want=%0d",
                 i, f, we, si, ss, ACC, exp_v);
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_scale();
    test_neg_scale();
    test_add();
    test_hold_wrap();
    test_select_priority();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu2.md
ALU2 -- requirements
Module: alu2

Interface
REQ-001 Parameter WIDTH, default 8: datapath width of ACC, Imm, SW and RegData.
REQ-002 Parameter FRAC_BITS, default 3: fractional bits of the MULI immediate (Q-format scale 2^FRAC_BITS).
REQ-003 Port Clock, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port nReset, input, 1: asynchronous, active-low reset.
REQ-005 Port Func, input, 3: operation code.
REQ-006 Port WE, input, 1: accumulator write enable.
REQ-007 Port SelImm, input, 1: selects Imm as operand B; has priority over SelSW.
REQ-008 Port SelSW, input, 1: selects SW as operand B when SelImm=0.
REQ-009 Port Imm, input, WIDTH, signed: immediate operand.
REQ-010 Port SW, input, WIDTH, signed: switch operand.
REQ-011 Port RegData, input, WIDTH, signed: register-file operand.
REQ-012 Port ACC, output, WIDTH, signed: accumulator, driven directly from a register.

Function
REQ-013 Operand B SHALL be: Imm if SelImm=1; else SW if SelSW=1; else RegData.
REQ-014 Func decode SHALL be:
- 000 ADD: ACC+B
- 001 RTA: B (load)
- 010 HEI: no write
- 011 LSW: B (load)
- 100 ADDI: ACC+B
- 101 MULI: (ACC*B)>>>FRAC_BITS
- 110 ATR: no write
- 111: reserved, no write
REQ-015 On a rising Clock edge with WE=1 and a writing opcode, ACC SHALL take the operation result.
REQ-016 For non-writing opcodes (010, 110, 111), ACC SHALL hold even when WE=1.
REQ-017 With WE=0, ACC SHALL hold for every Func value.
REQ-018 Latency SHALL be one clock: the result appears on ACC after the edge that samples the inputs.
REQ-019 Outside the ACC register the datapath SHALL be purely combinational; there SHALL be no other state.
REQ-020 Add SHALL be WIDTH-bit two's complement with wrap-around, with no saturation and no flags.
REQ-021 MULI SHALL form the full 2*WIDTH-bit signed product of ACC and B.
REQ-022 MULI SHALL then arithmetic-shift the product right by FRAC_BITS (rounding toward minus infinity) and keep the low WIDTH bits (wrap on overflow).
REQ-023 With the defaults, Imm=6 SHALL scale ACC by 0.75, Imm=4 by 0.5 and Imm=-4 (0xFC) by -0.5.
REQ-024 Loads (RTA, LSW) SHALL copy B unchanged.
REQ-025 Opcode and mux selects SHALL be decoded independently: an opcode combined with any SelImm/SelSW setting computes on the operand the selects choose.

Reset
REQ-026 When nReset=0, ACC SHALL go to 0 immediately, independent of Clock.
REQ-027 While nReset=0, ACC SHALL remain 0 regardless of WE, Func or Clock.
REQ-028 Normal operation SHALL resume at the first rising Clock edge after nReset returns to 1.
REQ-029 If reset is asserted mid-sequence, no partial result SHALL survive.

Verification
REQ-030 Reset: ACC=0x55, drive nReset=0 between clock edges -> ACC=0x00 at once, and ACC stays 0 over edges while nReset is held 0.
REQ-031 Load and scale: Func=011, SelSW=1, SW=40, WE=1 -> ACC=40; then Func=101, SelImm=1, Imm=6 -> ACC=30.
REQ-032 Negative scale and floor:
- ACC=40, MULI Imm=0xFC -> ACC=-20 (0xEC)
- ACC=-5, MULI Imm=6 -> ACC=-4
REQ-033 Register add and immediate add: ACC=20, Func=000, selects 0, RegData=30 -> ACC=50; then ADDI with Imm=0xEC -> ACC=30.
REQ-034 Hold and wrap:
- WE=0 for 3 edges with Func=000 -> ACC unchanged.
- WE=1, Func=110 -> ACC unchanged.
- ACC=127, ADDI Imm=20 -> ACC=-109 (0x93).
REQ-035 Select priority: SelImm=1, SelSW=1, Func=011, Imm=12, SW=99 -> ACC=12.
